// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: fetch and data ports share one memory bus with a
// single outstanding transaction; the data port wins unless fetch is starved.
module mem_arbiter #(
  parameter int wd_regs_p    = 32,
  parameter int wd_ramaddr_p = 32,
  parameter int starve_lim_p = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    i_if_req,
  input  logic [wd_ramaddr_p-1:0] i_if_addr,
  output logic                    o_if_gnt,
  output logic                    o_if_rvalid,
  output logic [wd_regs_p-1:0]    o_if_rdata,

  input  logic                    i_ls_req,
  input  logic                    i_ls_we,
  input  logic [3:0]              i_ls_be,
  input  logic [wd_ramaddr_p-1:0] i_ls_addr,
  input  logic [wd_regs_p-1:0]    i_ls_wdata,
  output logic                    o_ls_gnt,
  output logic                    o_ls_rvalid,
  output logic [wd_regs_p-1:0]    o_ls_rdata,

  output logic                    o_mem_req,
  output logic                    o_mem_we,
  output logic [3:0]              o_mem_be,
  output logic [wd_ramaddr_p-1:0] o_mem_addr,
  output logic [wd_regs_p-1:0]    o_mem_wdata,
  input  logic                    i_mem_gnt,
  input  logic                    i_mem_rvalid,
  input  logic [wd_regs_p-1:0]    i_mem_rdata,

  output logic                    o_err_unexp
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] WAIT_RESP = 1'b1;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  localparam int CNT_W = (starve_lim_p < 1) ? 1 : $clog2(starve_lim_p + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(starve_lim_p);

  logic [0:0]       r_state;
  logic             r_owner;
  logic [CNT_W-1:0] r_starveCnt;
  logic             r_errUnexp;

  logic w_idle;
  logic w_wait;
  logic w_starved;
  logic w_selLs;
  logic w_selIf;
  logic w_ifGnt;
  logic w_lsGnt;

  assign w_idle = (r_state == IDLE);
  assign w_wait = (r_state == WAIT_RESP);

  // Fetch overrides the data port only once it has watched starve_lim_p data grants go by.
  assign w_starved = i_if_req & (r_starveCnt == STARVE_LIM);
  assign w_selLs   = i_ls_req & ~w_starved;
  assign w_selIf   = i_if_req & ~w_selLs;

  assign w_ifGnt = rst_n & w_idle & w_selIf & i_mem_gnt;
  assign w_lsGnt = rst_n & w_idle & w_selLs & i_mem_gnt;

  assign o_if_gnt = w_ifGnt;
  assign o_ls_gnt = w_lsGnt;

  // Everything on the memory bus is forced to zero while in reset or waiting.
  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_be    = 4'h0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (rst_n && w_idle) begin
      o_mem_req = i_if_req | i_ls_req;
      if (w_selLs) begin
        o_mem_we    = i_ls_we;
        o_mem_be    = i_ls_be;
        o_mem_addr  = i_ls_addr;
        o_mem_wdata = i_ls_wdata;
      end else if (w_selIf) begin
        o_mem_be   = 4'hF;
        o_mem_addr = i_if_addr;
      end
    end
  end

  assign o_if_rvalid = rst_n & w_wait & i_mem_rvalid & (r_owner == OWN_IF);
  assign o_ls_rvalid = rst_n & w_wait & i_mem_rvalid & (r_owner == OWN_LS);
  assign o_if_rdata  = rst_n ? i_mem_rdata : '0;
  assign o_ls_rdata  = rst_n ? i_mem_rdata : '0;
  assign o_err_unexp = rst_n & r_errUnexp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_owner <= OWN_IF;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_ifGnt || w_lsGnt) begin
            r_state <= WAIT_RESP;
            r_owner <= w_lsGnt ? OWN_LS : OWN_IF;
          end
        end
        WAIT_RESP: begin
          if (i_mem_rvalid) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starveCnt <= '0;
    end else if (w_ifGnt) begin
      r_starveCnt <= '0;
    end else if (w_lsGnt) begin
      if (!i_if_req) begin
        r_starveCnt <= '0;
      end else if (r_starveCnt != STARVE_LIM) begin
        r_starveCnt <= r_starveCnt + CNT_W'(1);
      end
    end
  end

  // A response with nothing outstanding is latched until the next reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_errUnexp <= 1'b0;
    end else if (w_idle && i_mem_rvalid) begin
      r_errUnexp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: reset, fetch, data priority,
// starvation, backpressure, spurious response and reset mid-transaction.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt;
  logic        o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        i_ls_req;
  logic        i_ls_we;
  logic [3:0]  i_ls_be;
  logic [31:0] i_ls_addr;
  logic [31:0] i_ls_wdata;
  logic        o_ls_gnt;
  logic        o_ls_rvalid;
  logic [31:0] o_ls_rdata;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_err_unexp;

  int passCnt  = 0;
  int totalCnt = 0;

  mem_arbiter #(.wd_regs_p(32), .wd_ramaddr_p(32), .starve_lim_p(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_be(i_ls_be),
    .i_ls_addr(i_ls_addr), .i_ls_wdata(i_ls_wdata),
    .o_ls_gnt(o_ls_gnt), .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_err_unexp(o_err_unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic ifReq, input logic lsReq,
                               input logic memGnt, input logic memRvalid);
    i_if_req     = ifReq;
    i_ls_req     = lsReq;
    i_mem_gnt    = memGnt;
    i_mem_rvalid = memRvalid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    i_if_addr = 32'h44; i_ls_addr = 32'h88; i_ls_we = 1'b1; i_ls_be = 4'hF;
    i_ls_wdata = 32'hFFFF0000; i_mem_rdata = 32'h13572468;
    @(negedge clk); #1;
    totalCnt++; if (o_mem_req !== 1'b0) $display("[TB] FAIL rst_mem_req: got %0h expected 0", o_mem_req); else passCnt++;
    totalCnt++; if (o_mem_we !== 1'b0) $display("[TB] FAIL rst_mem_we: got %0h expected 0", o_mem_we); else passCnt++;
    totalCnt++; if (o_mem_be !== 4'h0) $display("[TB] FAIL rst_mem_be: got %0h expected 0", o_mem_be); else passCnt++;
    totalCnt++; if (o_mem_addr !== 32'h0) $display("[TB] FAIL rst_mem_addr: got %0h expected 0", o_mem_addr); else passCnt++;
    totalCnt++; if (o_mem_wdata !== 32'h0) $display("[TB] FAIL rst_mem_wdata: got %0h expected 0", o_mem_wdata); else passCnt++;
    totalCnt++; if ({o_if_gnt, o_ls_gnt} !== 2'b00) $display("[TB] FAIL rst_gnts: got %b expected 00", {o_if_gnt, o_ls_gnt}); else passCnt++;
    totalCnt++; if ({o_if_rvalid, o_ls_rvalid} !== 2'b00) $display("[TB] FAIL rst_rvalids: got %b expected 00", {o_if_rvalid, o_ls_rvalid}); else passCnt++;
    totalCnt++; if (o_if_rdata !== 32'h0 || o_ls_rdata !== 32'h0) $display("[TB] FAIL rst_rdata: got %0h/%0h expected 0/0", o_if_rdata, o_ls_rdata); else passCnt++;
    totalCnt++; if (o_err_unexp !== 1'b0) $display("[TB] FAIL rst_err: got %0h expected 0", o_err_unexp); else passCnt++;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    i_ls_we = 1'b0; i_ls_be = 4'h0;
    @(negedge clk); #1;
    totalCnt++; if (o_err_unexp !== 1'b0) $display("[TB] FAIL post_rst_err: got %0h expected 0", o_err_unexp); else passCnt++;
  endtask

  task automatic test_fetch();
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    i_if_addr = 32'h10;
    #1;
    totalCnt++; if (o_mem_req !== 1'b1) $display("[TB] FAIL fetch_mem_req: got %0h expected 1", o_mem_req); else passCnt++;
    totalCnt++; if ({o_if_gnt, o_ls_gnt} !== 2'b10) $display("[TB] FAIL fetch_gnts: got %b expected 10", {o_if_gnt, o_ls_gnt}); else passCnt++;
    totalCnt++; if (o_mem_addr !== 32'h10) $display("[TB] FAIL fetch_addr: got %0h expected 10", o_mem_addr); else passCnt++;
    totalCnt++; if (o_mem_we !== 1'b0 || o_mem_be !== 4'hF) $display("[TB] FAIL fetch_we_be: got %0h/%0h expected 0/f", o_mem_we, o_mem_be); else passCnt++;
    totalCnt++; if (o_mem_wdata !== 32'h0) $display("[TB] FAIL fetch_wdata: got %0h expected 0", o_mem_wdata); else passCnt++;
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    i_mem_rdata = 32'hDEADBEEF;
    #1;
    totalCnt++; if (o_mem_req !== 1'b0) $display("[TB] FAIL wait_mem_req: got %0h expected 0", o_mem_req); else passCnt++;
    totalCnt++; if ({o_if_gnt, o_ls_gnt} !== 2'b00) $display("[TB] FAIL wait_gnts: got %b expected 00", {o_if_gnt, o_ls_gnt}); else passCnt++;
    totalCnt++; if ({o_if_rvalid, o_ls_rvalid} !== 2'b10) $display("[TB] FAIL fetch_rvalid: got %b expected 10", {o_if_rvalid, o_ls_rvalid}); else passCnt++;
    totalCnt++; if (o_if_rdata !== 32'hDEADBEEF) $display("[TB] FAIL fetch_rdata: got %0h expected deadbeef", o_if_rdata); else passCnt++;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_data_priority();
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    i_if_addr = 32'h40; i_ls_we = 1'b1; i_ls_be = 4'h3;
    i_ls_addr = 32'h200; i_ls_wdata = 32'h12345678;
    #1;
    totalCnt++; if ({o_if_gnt, o_ls_gnt} !== 2'b01) $display("[TB] FAIL prio_gnts: got %b expected 01", {o_if_gnt, o_ls_gnt}); else passCnt++;
    totalCnt++; if (o_mem_we !== 1'b1 || o_mem_be !== 4'h3) $display("[TB] FAIL prio_we_be: got %0h/%0h expected 1/3", o_mem_we, o_mem_be); else passCnt++;
    totalCnt++; if (o_mem_addr !== 32'h200) $display("[TB] FAIL prio_addr: got %0h expected 200", o_mem_addr); else passCnt++;
    totalCnt++; if (o_mem_wdata !== 32'h12345678) $display("[TB] FAIL prio_wdata: got %0h expected 12345678", o_mem_wdata); else passCnt++;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    i_mem_rdata = 32'hCAFEF00D;
    #1;
    totalCnt++; if ({o_if_rvalid, o_ls_rvalid} !== 2'b01) $display("[TB] FAIL prio_rvalid: got %b expected 01", {o_if_rvalid, o_ls_rvalid}); else passCnt++;
    totalCnt++; if (o_ls_rdata !== 32'hCAFEF00D) $display("[TB] FAIL prio_rdata: got %0h expected cafef00d", o_ls_rdata); else passCnt++;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    i_ls_we = 1'b0; i_ls_be = 4'h0;
  endtask

  task automatic test_starvation();
    logic expLs;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      expLs = ((i % 5) != 4);
      @(negedge clk);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      #1;
      totalCnt++; if ({o_if_gnt, o_ls_gnt} !== {~expLs, expLs}) $display("[TB] FAIL starve_gnt_%0d: got %b expected %b", i, {o_if_gnt, o_ls_gnt}, {~expLs, expLs}); else passCnt++;
      @(negedge clk);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      #1;
      totalCnt++; if ({o_if_rvalid, o_ls_rvalid} !== {~expLs, expLs}) $display("[TB] FAIL starve_rvalid_%0d: got %b expected %b", i, {o_if_rvalid, o_ls_rvalid}, {~expLs, expLs}); else passCnt++;
    end
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    i_if_addr = 32'h80;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      totalCnt++; if (o_mem_req !== 1'b1) $display("[TB] FAIL bp_req_%0d: got %0h expected 1", k, o_mem_req); else passCnt++;
      totalCnt++; if ({o_if_gnt, o_ls_gnt} !== 2'b00) $display("[TB] FAIL bp_gnt_%0d: got %b expected 00", k, {o_if_gnt, o_ls_gnt}); else passCnt++;
    end
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    totalCnt++; if ({o_if_gnt, o_ls_gnt} !== 2'b10) $display("[TB] FAIL bp_final_gnt: got %b expected 10", {o_if_gnt, o_ls_gnt}); else passCnt++;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    totalCnt++; if (o_if_gnt !== 1'b0) $display("[TB] FAIL bp_single_gnt: got %0h expected 0", o_if_gnt); else passCnt++;
    totalCnt++; if (o_if_rvalid !== 1'b1) $display("[TB] FAIL bp_rvalid: got %0h expected 1", o_if_rvalid); else passCnt++;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    totalCnt++; if (o_err_unexp !== 1'b0) $display("[TB] FAIL bp_err: got %0h expected 0", o_err_unexp); else passCnt++;
  endtask

  task automatic test_spurious();
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    i_mem_rdata = 32'h55;
    #1;
    totalCnt++; if ({o_if_rvalid, o_ls_rvalid} !== 2'b00) $display("[TB] FAIL spur_rvalid: got %b expected 00", {o_if_rvalid, o_ls_rvalid}); else passCnt++;
    totalCnt++; if (o_err_unexp !== 1'b0) $display("[TB] FAIL spur_err_before: got %0h expected 0", o_err_unexp); else passCnt++;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    totalCnt++; if (o_err_unexp !== 1'b1) $display("[TB] FAIL spur_err_set: got %0h expected 1", o_err_unexp); else passCnt++;
    @(negedge clk); #1;
    totalCnt++; if (o_err_unexp !== 1'b1) $display("[TB] FAIL spur_err_held: got %0h expected 1", o_err_unexp); else passCnt++;
    @(negedge clk); rst_n = 1'b0; #1;
    totalCnt++; if (o_err_unexp !== 1'b0) $display("[TB] FAIL spur_err_in_rst: got %0h expected 0", o_err_unexp); else passCnt++;
    @(negedge clk); rst_n = 1'b1; #1;
    totalCnt++; if (o_err_unexp !== 1'b0) $display("[TB] FAIL spur_err_cleared: got %0h expected 0", o_err_unexp); else passCnt++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    i_ls_we = 1'b1; i_ls_be = 4'hC; i_ls_addr = 32'h300; i_ls_wdata = 32'h0BADF00D;
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    i_mem_rdata = 32'hA5A5A5A5;
    #1;
    totalCnt++; if ({o_mem_req, o_mem_we, o_mem_be} !== 6'h0) $display("[TB] FAIL mid_rst_bus: got %b expected 000000", {o_mem_req, o_mem_we, o_mem_be}); else passCnt++;
    totalCnt++; if (o_mem_addr !== 32'h0 || o_mem_wdata !== 32'h0) $display("[TB] FAIL mid_rst_addr_wdata: got %0h/%0h expected 0/0", o_mem_addr, o_mem_wdata); else passCnt++;
    totalCnt++; if ({o_if_gnt, o_ls_gnt, o_if_rvalid, o_ls_rvalid} !== 4'h0) $display("[TB] FAIL mid_rst_ctrl: got %b expected 0000", {o_if_gnt, o_ls_gnt, o_if_rvalid, o_ls_rvalid}); else passCnt++;
    totalCnt++; if (o_if_rdata !== 32'h0 || o_ls_rdata !== 32'h0) $display("[TB] FAIL mid_rst_rdata: got %0h/%0h expected 0/0", o_if_rdata, o_ls_rdata); else passCnt++;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    totalCnt++; if ({o_if_rvalid, o_ls_rvalid} !== 2'b00) $display("[TB] FAIL mid_late_rvalid: got %b expected 00", {o_if_rvalid, o_ls_rvalid}); else passCnt++;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    i_ls_we = 1'b0; i_ls_be = 4'h0;
    #1;
    totalCnt++; if (o_err_unexp !== 1'b1) $display("[TB] FAIL mid_late_err: got %0h expected 1", o_err_unexp); else passCnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    i_if_addr = '0; i_ls_we = 1'b0; i_ls_be = 4'h0;
    i_ls_addr = '0; i_ls_wdata = '0; i_mem_rdata = '0;
    test_reset();
    test_fetch();
    test_data_priority();
    test_starvation();
    test_backpressure();
    test_spurious();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
